// File: rtl/keypad_scanner.sv
// Matrix keypad front end: scans the columns, debounces whole frames and issues
// one valid/ready event carrying the translated key code for each accepted press.
module keypad_scanner #(
  parameter int ROWS      = 4,
  parameter int COLS      = 4,
  parameter int CODE_W    = 4,
  parameter int SCAN_DIV  = 1000,
  parameter int DEBOUNCE  = 4,
  parameter int TRANSLATE = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [COLS-1:0]   col_drive,
  input  logic [ROWS-1:0]   row_sense,
  output logic [CODE_W-1:0] key_code,
  output logic              key_valid,
  input  logic              key_ready,
  output logic              key_held,
  output logic              multi_key,
  output logic              overrun
);

  localparam int KEYS   = ROWS * COLS;
  localparam int IDX_W  = (KEYS > 1) ? $clog2(KEYS) : 1;
  localparam int COL_W  = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int SLOT_W = $clog2(SCAN_DIV);
  localparam int CNT_W  = $clog2(DEBOUNCE + 1);

  typedef enum logic [1:0] {IDLE, DEB_PRESS, HELD, DEB_REL} state_t;

  logic [ROWS-1:0]   sync1_reg, sync2_reg;
  logic              started_reg;
  logic [COL_W-1:0]  col_reg;
  logic [SLOT_W-1:0] slot_reg;
  logic [1:0]        acc_cnt_reg;
  logic [IDX_W-1:0]  acc_idx_reg;
  logic [1:0]        samp_cnt;
  logic [IDX_W-1:0]  samp_idx;
  logic              sample, frame_end, emit;
  state_t            state_reg, state_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic [IDX_W-1:0]  cand_reg, cand_next;
  logic [CODE_W-1:0] key_code_reg;
  logic              key_valid_reg, multi_key_reg, overrun_reg;

  function automatic logic [CODE_W-1:0] map_code(input logic [IDX_W-1:0] idx);
    logic [3:0] calc;
    calc = 4'h0;
    if (TRANSLATE != 0) begin
      case (32'(idx))
        0:  calc = 4'h1;
        1:  calc = 4'h2;
        2:  calc = 4'h3;
        3:  calc = 4'hA;
        4:  calc = 4'h4;
        5:  calc = 4'h5;
        6:  calc = 4'h6;
        7:  calc = 4'hB;
        8:  calc = 4'h7;
        9:  calc = 4'h8;
        10: calc = 4'h9;
        11: calc = 4'hC;
        12: calc = 4'hE;
        13: calc = 4'h0;
        14: calc = 4'hF;
        default: calc = 4'hD;
      endcase
      return CODE_W'(calc);
    end
    return CODE_W'(idx);
  endfunction

  // Columns stay released until the first cycle after reset.
  generate
    for (genvar gi = 0; gi < COLS; gi++) begin : g_col
      assign col_drive[gi] = !(started_reg && col_reg == COL_W'(gi));
    end
  endgenerate

  assign sample    = started_reg && (slot_reg == SLOT_W'(SCAN_DIV - 1));
  assign frame_end = sample && (col_reg == COL_W'(COLS - 1));

  // Pressed-position count saturates at 2: only none/one/many matters.
  always_comb begin
    samp_cnt = acc_cnt_reg;
    samp_idx = acc_idx_reg;
    for (int r = 0; r < ROWS; r++) begin
      if (!sync2_reg[r]) begin
        if (samp_cnt != 2'd2) samp_cnt = samp_cnt + 2'd1;
        samp_idx = IDX_W'(r * COLS) + IDX_W'(col_reg);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_reg   <= '1;
      sync2_reg   <= '1;
      started_reg <= 1'b0;
      col_reg     <= '0;
      slot_reg    <= '0;
      acc_cnt_reg <= '0;
      acc_idx_reg <= '0;
    end else begin
      sync1_reg <= row_sense;
      sync2_reg <= sync1_reg;
      if (!started_reg) begin
        started_reg <= 1'b1;
      end else if (sample) begin
        slot_reg    <= '0;
        col_reg     <= (col_reg == COL_W'(COLS - 1)) ? '0 : col_reg + COL_W'(1);
        acc_cnt_reg <= frame_end ? 2'd0 : samp_cnt;
        acc_idx_reg <= samp_idx;
      end else begin
        slot_reg <= slot_reg + SLOT_W'(1);
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    cand_next  = cand_reg;
    emit       = 1'b0;
    if (frame_end) begin
      case (state_reg)
        IDLE: begin
          if (samp_cnt == 2'd1) begin
            cand_next = samp_idx;
            if (DEBOUNCE == 1) begin
              emit       = 1'b1;
              state_next = HELD;
            end else begin
              cnt_next   = CNT_W'(1);
              state_next = DEB_PRESS;
            end
          end
        end
        DEB_PRESS: begin
          if (samp_cnt == 2'd1 && samp_idx == cand_reg) begin
            cnt_next = cnt_reg + CNT_W'(1);
            if (cnt_reg + CNT_W'(1) == CNT_W'(DEBOUNCE)) begin
              emit       = 1'b1;
              state_next = HELD;
            end
          end else begin
            state_next = IDLE;
          end
        end
        HELD: begin
          if (samp_cnt == 2'd0) begin
            cnt_next   = CNT_W'(1);
            state_next = (DEBOUNCE == 1) ? IDLE : DEB_REL;
          end
        end
        default: begin
          if (samp_cnt == 2'd0) begin
            cnt_next = cnt_reg + CNT_W'(1);
            if (cnt_reg + CNT_W'(1) == CNT_W'(DEBOUNCE)) state_next = IDLE;
          end else begin
            state_next = HELD;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      cand_reg  <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      cand_reg  <= cand_next;
    end
  end

  // A new event may replace one being accepted in the same cycle; otherwise it is dropped.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      key_code_reg  <= '0;
      key_valid_reg <= 1'b0;
      multi_key_reg <= 1'b0;
      overrun_reg   <= 1'b0;
    end else begin
      if (frame_end) multi_key_reg <= (samp_cnt == 2'd2);
      if (emit) begin
        if (!key_valid_reg || key_ready) begin
          key_code_reg  <= map_code(cand_next);
          key_valid_reg <= 1'b1;
          if (key_valid_reg) overrun_reg <= 1'b0;
        end else begin
          overrun_reg <= 1'b1;
        end
      end else if (key_valid_reg && key_ready) begin
        key_valid_reg <= 1'b0;
        overrun_reg   <= 1'b0;
      end
    end
  end

  assign key_code  = key_code_reg;
  assign key_valid = key_valid_reg;
  assign multi_key = multi_key_reg;
  assign overrun   = overrun_reg;
  assign key_held  = (state_reg == HELD) || (state_reg == DEB_REL);

endmodule

// File: tb/tb_keypad_scanner.sv
// Drives a 4x4 calculator-map scanner and a 3x4 raw-map scanner from one simulated
// key matrix and checks both against a frame-level reference model every cycle.
module tb_keypad_scanner;

  localparam int SD    = 4;
  localparam int DB    = 2;
  localparam int FRAME = 4 * SD;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        key_ready = 1'b0;
  logic [15:0] pattern = '0;
  logic [3:0]  col_a, col_b, code_a, code_b;
  logic [3:0]  row_a;
  logic [2:0]  row_b;
  logic        valid_a, valid_b, held_a, held_b, multi_a, multi_b, ovr_a, ovr_b;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int ready_mode = 1;
  int calc_map [16] = '{1, 2, 3, 10, 4, 5, 6, 11, 7, 8, 9, 12, 14, 0, 15, 13};

  // Reference model state per DUT (0: calculator 4x4, 1: raw 3x4)
  int m_run [2];
  int m_rel [2];
  int m_cand [2];
  int m_code [2];
  bit m_held [2];
  bit m_valid [2];
  bit m_ovr [2];
  bit m_multi [2];

  always #5 clk = ~clk;

  keypad_scanner #(.ROWS(4), .COLS(4), .CODE_W(4), .SCAN_DIV(SD), .DEBOUNCE(DB), .TRANSLATE(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .col_drive(col_a), .row_sense(row_a), .key_code(code_a),
    .key_valid(valid_a), .key_ready(key_ready), .key_held(held_a), .multi_key(multi_a), .overrun(ovr_a));

  keypad_scanner #(.ROWS(3), .COLS(4), .CODE_W(4), .SCAN_DIV(SD), .DEBOUNCE(DB), .TRANSLATE(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .col_drive(col_b), .row_sense(row_b), .key_code(code_b),
    .key_valid(valid_b), .key_ready(key_ready), .key_held(held_b), .multi_key(multi_b), .overrun(ovr_b));

  // Pressed switch at (r,c) pulls row r low while column c is driven low.
  always_comb begin
    row_a = '1;
    row_b = '1;
    for (int r = 0; r < 4; r++) row_a[r] = ~|(pattern[r*4 +: 4] & ~col_a);
    for (int r = 0; r < 3; r++) row_b[r] = ~|(pattern[r*4 +: 4] & ~col_b);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", tag, cyc, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_run[d] = 0; m_rel[d] = 0; m_cand[d] = 0; m_code[d] = 0;
      m_held[d] = 0; m_valid[d] = 0; m_ovr[d] = 0; m_multi[d] = 0;
    end
  endtask

  task automatic drive_ready();
    case (ready_mode)
      0: key_ready = 1'b0;
      1: key_ready = 1'b1;
      default: key_ready = 1'($urandom_range(0, 1));
    endcase
  endtask

  task automatic compare_all();
    logic [3:0] exp_col;
    exp_col = ~(4'b0001 << ((cyc % FRAME) / SD));
    check("col_a", 32'(col_a), 32'(exp_col));
    check("col_b", 32'(col_b), 32'(exp_col));
    check("valid_a", 32'(valid_a), 32'(m_valid[0]));
    check("valid_b", 32'(valid_b), 32'(m_valid[1]));
    check("code_a", 32'(code_a), 32'(m_code[0]));
    check("code_b", 32'(code_b), 32'(m_code[1]));
    check("ovr_a", 32'(ovr_a), 32'(m_ovr[0]));
    check("ovr_b", 32'(ovr_b), 32'(m_ovr[1]));
    check("held_a", 32'(held_a), 32'(m_held[0]));
    check("held_b", 32'(held_b), 32'(m_held[1]));
    check("multi_a", 32'(multi_a), 32'(m_multi[0]));
    check("multi_b", 32'(multi_b), 32'(m_multi[1]));
  endtask

  // One clock edge: update the model with what the DUTs saw at that edge, then compare.
  task automatic step();
    bit rdy;
    rdy = key_ready;
    @(posedge clk);
    cyc++;
    for (int d = 0; d < 2; d++) begin
      bit emit;
      int code;
      emit = 0;
      code = 0;
      if (cyc % FRAME == 0) begin
        logic [15:0] p;
        int n, x;
        p = (d == 0) ? pattern : (pattern & 16'h0FFF);
        n = $countones(p);
        x = 0;
        for (int i = 15; i >= 0; i--) if (p[i]) x = i;
        m_multi[d] = (n >= 2);
        if (!m_held[d]) begin
          if (m_run[d] == 0) begin
            if (n == 1) begin m_cand[d] = x; m_run[d] = 1; end
          end else if (n == 1 && x == m_cand[d]) begin
            m_run[d]++;
          end else begin
            m_run[d] = 0;
          end
          if (m_run[d] == DB) begin emit = 1; m_held[d] = 1; m_run[d] = 0; end
        end else if (n == 0) begin
          m_rel[d]++;
          if (m_rel[d] == DB) begin m_held[d] = 0; m_rel[d] = 0; end
        end else begin
          m_rel[d] = 0;
        end
        code = (d == 0) ? calc_map[m_cand[d]] : m_cand[d];
      end
      if (emit) begin
        if (!m_valid[d] || rdy) begin
          if (m_valid[d]) m_ovr[d] = 0;
          m_valid[d] = 1;
          m_code[d] = code;
          $display("dut%0d cycle %0d: press event code %0h", d, cyc, code);
        end else begin
          m_ovr[d] = 1;
          $display("dut%0d cycle %0d: press code %0h dropped, event pending", d, cyc, code);
        end
      end else if (m_valid[d] && rdy) begin
        m_valid[d] = 0;
        m_ovr[d] = 0;
        $display("dut%0d cycle %0d: event code %0h accepted", d, cyc, m_code[d]);
      end
    end
    #1;
    compare_all();
    drive_ready();
  endtask

  task automatic run_frame(input logic [15:0] pat, input int mode);
    pattern = pat;
    ready_mode = mode;
    drive_ready();
    repeat (FRAME) step();
  endtask

  task automatic do_reset(input int cycles);
    rst_n = 1'b0;
    repeat (cycles) @(posedge clk);
    #1;
    check("rst_col_a", 32'(col_a), 32'hF);
    check("rst_col_b", 32'(col_b), 32'hF);
    check("rst_valid_a", 32'(valid_a), 32'h0);
    check("rst_code_a", 32'(code_a), 32'h0);
    check("rst_held_a", 32'(held_a), 32'h0);
    check("rst_multi_a", 32'(multi_a), 32'h0);
    check("rst_ovr_a", 32'(ovr_a), 32'h0);
    check("rst_valid_b", 32'(valid_b), 32'h0);
    rst_n = 1'b1;
    model_reset();
    cyc = 0;
    @(posedge clk);
    #1;
    compare_all();
  endtask

  initial begin
    model_reset();
    do_reset(3);

    // Clean press of '5', fully released afterwards
    repeat (6) run_frame(16'h0020, 1);
    check("s1_code_a", 32'(code_a), 32'h5);
    check("s1_held_a", 32'(held_a), 32'h1);
    repeat (4) run_frame(16'h0000, 1);
    check("s1_rel_held_a", 32'(held_a), 32'h0);

    // Bounce on '#': glitch frame must not produce an event
    run_frame(16'h4000, 1);
    run_frame(16'h0000, 1);
    repeat (3) run_frame(16'h4000, 1);
    check("s2_code_a", 32'(code_a), 32'hF);
    check("s2_multi_a", 32'(multi_a), 32'h0);
    repeat (3) run_frame(16'h0000, 1);

    // Two keys together, then the second one lets go
    repeat (4) run_frame(16'h0801, 1);
    check("s3_multi_a", 32'(multi_a), 32'h1);
    check("s3_multi_b", 32'(multi_b), 32'h1);
    check("s3_held_a", 32'(held_a), 32'h0);
    repeat (3) run_frame(16'h0001, 1);
    check("s3_code_a", 32'(code_a), 32'h1);
    check("s3_code_b", 32'(code_b), 32'h0);
    repeat (3) run_frame(16'h0000, 1);

    // Raw map on the 3-row scanner: row2/col3
    repeat (3) run_frame(16'h0800, 1);
    check("s4_code_b", 32'(code_b), 32'hB);
    repeat (3) run_frame(16'h0000, 1);

    // Overrun: '0' then '9' with the consumer stalled
    repeat (3) run_frame(16'h2000, 0);
    repeat (3) run_frame(16'h0000, 0);
    repeat (3) run_frame(16'h0400, 0);
    check("s5_valid_a", 32'(valid_a), 32'h1);
    check("s5_code_a", 32'(code_a), 32'h0);
    check("s5_ovr_a", 32'(ovr_a), 32'h1);
    run_frame(16'h0000, 1);
    check("s5_acc_valid_a", 32'(valid_a), 32'h0);
    check("s5_acc_ovr_a", 32'(ovr_a), 32'h0);
    repeat (3) run_frame(16'h0000, 1);

    // Reset while debouncing a press of '6'
    run_frame(16'h0040, 1);
    do_reset(1);
    run_frame(16'h0040, 1);
    check("s6_no_early_a", 32'(valid_a), 32'h0);
    run_frame(16'h0040, 0);
    check("s6_valid_a", 32'(valid_a), 32'h1);
    check("s6_code_a", 32'(code_a), 32'h6);
    repeat (3) run_frame(16'h0000, 1);

    // Randomised key activity and consumer stalls
    for (int f = 0; f < 200; f++) begin
      int kind;
      logic [15:0] pat;
      kind = $urandom_range(0, 9);
      pat = pattern;
      if (kind >= 4 && kind <= 5) pat = '0;
      else if (kind >= 6 && kind <= 8) pat = 16'h1 << $urandom_range(0, 15);
      else if (kind == 9) pat = (16'h1 << $urandom_range(0, 15)) | (16'h1 << $urandom_range(0, 15));
      run_frame(pat, $urandom_range(0, 2));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
- Parametrised matrix-keypad front end for the calculator datapath.
- Drives keypad columns one at a time and samples the rows.
- Debounces press and release, and translates the key position into a calculator key code.
- Delivers exactly one valid/ready event per physical press, replacing the level-based combinational translator.

Parameters:
- ROWS, 4, number of row sense lines.
- COLS, 4, number of column drive lines.
- CODE_W, 4, key_code width; must be >= clog2(ROWS*COLS).
- SCAN_DIV, 1000, clock cycles each column is driven (>= 3).
- DEBOUNCE, 4, consecutive identical frames required to accept a press or a release (>= 1).
- TRANSLATE, 1, selects the code map: 1 = calculator map (legal only when ROWS=COLS=4); 0 = raw index row*COLS+col.

Ports:
- clk, input, 1, system clock.
- rst_n, input, 1, synchronous active-low reset.
- col_drive, output, COLS, active-low one-hot column drive.
- row_sense, input, ROWS, active-low row inputs (asynchronous, pulled up).
- key_code, output, CODE_W, code of the accepted key.
- key_valid, output, 1, event pending; held until accepted.
- key_ready, input, 1, consumer accepts the event when key_valid and key_ready are both high.
- key_held, output, 1, high while an accepted key is still held (FSM in HELD or DEB_REL).
- multi_key, output, 1, last completed frame saw two or more pressed positions.
- overrun, output, 1, sticky: a press was dropped because an event was already pending.

Behaviour:
- Reset (rst_n low at a clk edge):
  - col_drive = all ones; key_code = 0; key_valid = 0; key_held = 0; multi_key = 0; overrun = 0.
  - FSM = IDLE; column index = 0; slot counter = 0; synchroniser flops set to all ones.
  - Reset mid-operation abandons any debounce in progress and any pending event.
- Synchroniser: row_sense passes through a 2-flop synchroniser before any use.
- Scanning:
  - Column c is driven low for SCAN_DIV cycles; all other columns stay high.
  - Order is 0..COLS-1, then wraps to 0.
  - First slot starts on the first cycle after reset is released.
  - Rows are sampled on the last cycle of each slot, so the synchroniser has settled.
  - A frame is one pass over all COLS slots (COLS*SCAN_DIV cycles).
- Frame end (after the column COLS-1 sample), the result is classified as:
  - NONE: zero pressed positions.
  - SINGLE(idx): exactly one pressed position, idx = row*COLS+col.
  - MULTI: two or more pressed positions.
  - multi_key is updated to (result == MULTI) at every frame end.
- FSM, evaluated only at frame end:
  - IDLE: SINGLE → DEB_PRESS with cand = idx, cnt = 1. NONE or MULTI → stay.
  - DEB_PRESS: SINGLE(cand) → cnt+1. When cnt reaches DEBOUNCE, emit the event and go to HELD. Any other result → IDLE.
  - DEBOUNCE = 1 is the special case: IDLE emits on the first SINGLE and goes directly to HELD.
  - HELD: NONE → DEB_REL with cnt = 1 (or → IDLE directly if DEBOUNCE = 1). Anything else → stay; a second key or a key change does not generate an event.
  - DEB_REL: NONE → cnt+1; at DEBOUNCE → IDLE. Any press → HELD.
- Emit:
  - If key_valid = 0: load key_code = map(cand) and set key_valid = 1.
  - If key_valid = 1 and key_ready = 1 in the same cycle: the old event is accepted, the new code is loaded, key_valid stays 1, and overrun is not set.
  - If key_valid = 1 and key_ready = 0: the new press is dropped, key_code is unchanged, and overrun is set to 1.
- Handshake:
  - key_valid falls the cycle after an accept unless a new event is emitted in that cycle.
  - key_code stays stable while key_valid = 1.
  - overrun clears on the next accept or on reset.
- Latency: key_valid rises at most (DEBOUNCE+1) frames + 3 cycles after a clean, stable press.
- Calculator map (TRANSLATE = 1), idx 0..15 → code: 1, 2, 3, A, 4, 5, 6, B, 7, 8, 9, C, E(*), 0, F(#), D(=).
- Raw map (TRANSLATE = 0): key_code = idx, zero-extended to CODE_W.

Test Plan:
- Default map, DEBOUNCE=2, SCAN_DIV=4: hold row1/col1 for 6 frames, key_ready=1 → exactly one key_valid pulse with key_code=0x5; key_held=1 until DEB_REL completes.
- Bounce: press row3/col2 for 1 frame, release 1 frame, press 3 frames → single event with code 0xF and no event for the glitch; multi_key=0.
- Multi-key: hold row0/col0 and row2/col3 together for 4 frames → multi_key=1, no event; release row2/col3 → after DEBOUNCE frames, event code 0x1.
- Overrun: key_ready=0, press/release 0 then press 9 → key_valid=1, key_code=0x0, overrun=1; raise key_ready → 0x0 accepted, overrun clears, key_valid falls.
- Reset mid-debounce: pull rst_n low during DEB_PRESS for 1 cycle → all outputs at reset values; the same held key needs a full DEBOUNCE again before key_valid.
- TRANSLATE=0, ROWS=3, COLS=4, CODE_W=4: press row2/col3 → key_code=0xB; col_drive cycles 1110 → 1101 → 1011 → 0111.
